// File: rtl/router_fsm.sv
// Packet control FSM for the 1x3 router: decodes the header address and
// sequences header, payload and parity loading into router_sync.
module router_fsm (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       e0,
    input  logic       e1,
    input  logic       e2,
    input  logic       sr0,
    input  logic       sr1,
    input  logic       sr2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_addr;

    // Padded to 4 entries so a 2-bit index never falls out of range.
    logic [3:0] w_empty;
    logic [3:0] w_sr;
    logic       w_hdr_ok;
    logic       w_soft_rst;

    assign w_empty    = {1'b0, e2, e1, e0};
    assign w_sr       = {1'b0, sr2, sr1, sr0};
    assign w_hdr_ok   = pkt_valid && (data_in != 2'd3);
    assign w_soft_rst = w_sr[r_addr] && (r_state != DECODE_ADDRESS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE_ADDRESS && w_hdr_ok)
                r_addr <= data_in;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (w_hdr_ok)
                    w_next = w_empty[data_in] ? LOAD_FIRST_DATA
                                              : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty[r_addr])
                    w_next = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    w_next = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    w_next = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    w_next = LOAD_PARITY;
                else
                    w_next = LOAD_DATA;
            end
            LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: w_next = DECODE_ADDRESS;
        endcase
        // Soft reset of the addressed FIFO abandons the packet.
        if (w_soft_rst)
            w_next = DECODE_ADDRESS;
    end

    always_comb begin
        detect_addr   = (r_state == DECODE_ADDRESS);
        lfd_state     = (r_state == LOAD_FIRST_DATA);
        ld_state      = (r_state == LOAD_DATA);
        laf_state     = (r_state == LOAD_AFTER_FULL);
        full_state    = (r_state == FIFO_FULL_STATE);
        rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        write_enb_reg = (r_state == LOAD_DATA)
                     || (r_state == LOAD_PARITY)
                     || (r_state == LOAD_AFTER_FULL);
        busy          = !((r_state == DECODE_ADDRESS)
                       || (r_state == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus queues the expected Moore
// output vector per cycle, a negedge monitor pops and compares.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       e0, e1, e2;
    logic       sr0, sr1, sr2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_addr, lfd_state, ld_state, laf_state;
    logic       full_state, write_enb_reg, rst_int_reg, busy;

    int checks   = 0;
    int failures = 0;

    typedef enum int {
        S_DA, S_LFD, S_LD, S_LP, S_FULL, S_LAF, S_WTE, S_CPE
    } st_e;

    // {detect, lfd, ld, laf, full, we, rst_int, busy}
    logic [7:0] exp_q[$];

    router_fsm dut (
        .clk           (clk),
        .rstn          (rstn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .e0            (e0),
        .e1            (e1),
        .e2            (e2),
        .sr0           (sr0),
        .sr1           (sr1),
        .sr2           (sr2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_addr   (detect_addr),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vec(st_e s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0100;
            S_LAF:   return 8'b0001_0101;
            S_FULL:  return 8'b0000_1001;
            S_LP:    return 8'b0000_0101;
            S_CPE:   return 8'b0000_0011;
            default: return 8'b0000_0001;
        endcase
    endfunction

    function automatic logic [7:0] act();
        return {detect_addr, lfd_state, ld_state, laf_state,
                full_state, write_enb_reg, rst_int_reg, busy};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%b want=%b",
                         $time, act(), e);
            end
        end
    end

    task automatic cyc(input st_e s);
        exp_q.push_back(vec(s));
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 0; pkt_valid = 0; data_in = 0; fifo_full = 0;
        e0 = 1; e1 = 1; e2 = 1; sr0 = 0; sr1 = 0; sr2 = 0;
        parity_done = 0; low_pkt_valid = 0;
        #2;
        chk("reset_async", act(), vec(S_DA));
        cyc(S_DA);
        cyc(S_DA);
        rstn = 1;

        // 1: basic packet to FIFO1
        pkt_valid = 1; data_in = 1;
        cyc(S_LFD);
        data_in = 3;
        cyc(S_LD);
        data_in = 2;
        cyc(S_LD);
        cyc(S_LD);
        cyc(S_LD);
        pkt_valid = 0;
        cyc(S_LP);
        cyc(S_CPE);
        cyc(S_DA);

        // 2: FIFO2 not empty, wait 6 cycles
        pkt_valid = 1; data_in = 2; e2 = 0;
        for (int i = 0; i < 6; i++) cyc(S_WTE);
        e2 = 1;
        cyc(S_LFD);
        cyc(S_LD);

        // 3: full stall, then low_pkt_valid
        fifo_full = 1;
        for (int i = 0; i < 3; i++) cyc(S_FULL);
        fifo_full = 0; low_pkt_valid = 1; pkt_valid = 0;
        cyc(S_LAF);
        cyc(S_LP);
        low_pkt_valid = 0;
        cyc(S_CPE);
        cyc(S_DA);

        // 4: invalid header address
        pkt_valid = 1; data_in = 3;
        cyc(S_DA);
        cyc(S_DA);
        chk("addr_hold", {6'd0, dut.r_addr}, 8'd2);
        pkt_valid = 0;

        // 5a: sr0 aborts a stalled FIFO0 packet
        pkt_valid = 1; data_in = 0;
        cyc(S_LFD);
        cyc(S_LD);
        fifo_full = 1;
        cyc(S_FULL);
        cyc(S_FULL);
        sr0 = 1;
        cyc(S_DA);
        sr0 = 0; fifo_full = 0; pkt_valid = 0;
        cyc(S_DA);

        // 5b: sr1 is ignored for a FIFO0 packet
        pkt_valid = 1; data_in = 0;
        cyc(S_LFD);
        cyc(S_LD);
        fifo_full = 1;
        cyc(S_FULL);
        sr1 = 1;
        cyc(S_FULL);
        sr1 = 0;
        cyc(S_FULL);
        fifo_full = 0;
        cyc(S_LAF);
        pkt_valid = 1;
        cyc(S_LD);
        fifo_full = 1;
        cyc(S_FULL);
        fifo_full = 0; parity_done = 1;
        cyc(S_LAF);
        cyc(S_DA);
        parity_done = 0; pkt_valid = 0;

        // 6: async reset between edges mid-LOAD_DATA
        pkt_valid = 1; data_in = 1;
        cyc(S_LFD);
        cyc(S_LD);
        @(negedge clk);
        #2;
        rstn = 0;
        #1;
        chk("async_ld", {7'd0, ld_state}, 8'd0);
        chk("async_da", {7'd0, detect_addr}, 8'd1);
        cyc(S_DA);
        rstn = 1; pkt_valid = 0;
        cyc(S_DA);
        cyc(S_DA);

        @(negedge clk);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
